// File: rtl/uart_rx_decoder_pkg.sv
// Shared constants and the ASCII symbol decoder for the UART receive path.
// fnASCII2Nib is the inverse of the transmit-side symbol-to-ASCII mapping.
package uart_rx_decoder_pkg;

  localparam int uart_num_nib = 2;
  localparam int seq_dp_width = 8 * uart_num_nib;

  localparam logic [1:0] ERR_BADCHAR = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

  typedef enum logic [1:0] {
    stCollect = 2'd0,
    stTerm    = 2'd1,
    stDiscard = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       is_sym;
    logic       is_term;
  } dec_t;

  // '0'-'9' -> 0x00-0x09, 'A'-'Z' and 'a'-'z' -> 0x0A-0x23, LF or CR terminate.
  function automatic dec_t fnASCII2Nib(input logic [7:0] c);
    dec_t r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.code   = c - 8'h30;
      r.is_sym = 1'b1;
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      r.code   = c - 8'h41 + 8'd10;
      r.is_sym = 1'b1;
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      r.code   = c - 8'h61 + 8'd10;
      r.is_sym = 1'b1;
    end else if (c == 8'h0A || c == 8'h0D) begin
      r.is_term = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_decoder.sv
// Decodes received ASCII lines into packed symbol words for the sequencer,
// rejecting malformed lines and reporting overruns of the holding register.
module uart_rx_decoder
  import uart_rx_decoder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic [seq_dp_width-1:0] o_word,
  output logic                    o_word_valid,
  input  logic                    i_word_rdy,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic                    o_overrun
);

  localparam int CNT_W = $clog2(uart_num_nib + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(uart_num_nib - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [seq_dp_width-1:0] r_shreg;
  dec_t                    w_dec;
  logic                    w_can_load;

  assign w_dec      = fnASCII2Nib(i_rx_data);
  assign w_can_load = !o_word_valid || i_word_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= stCollect;
      r_cnt        <= '0;
      r_shreg      <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_err        <= 1'b0;
      o_err_code   <= 2'd0;
      o_overrun    <= 1'b0;
    end else begin
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
      o_overrun  <= 1'b0;
      // A commit later in this block overrides the handshake clear.
      if (o_word_valid && i_word_rdy)
        o_word_valid <= 1'b0;

      if (i_rx_valid) begin
        unique case (r_state)
          stCollect: begin
            if (w_dec.is_sym) begin
              r_shreg <= {r_shreg[seq_dp_width-9:0], w_dec.code};
              r_cnt   <= r_cnt + 1'b1;
              if (r_cnt == LAST_CNT)
                r_state <= stTerm;
            end else if (w_dec.is_term) begin
              // Empty lines and the second byte of a CR/LF pair fall through.
              if (r_cnt != '0) begin
                o_err      <= 1'b1;
                o_err_code <= ERR_SHORT;
                r_cnt      <= '0;
              end
            end else begin
              o_err      <= 1'b1;
              o_err_code <= ERR_BADCHAR;
              r_state    <= stDiscard;
            end
          end
          stTerm: begin
            if (w_dec.is_term) begin
              r_cnt   <= '0;
              r_state <= stCollect;
              if (w_can_load) begin
                o_word       <= r_shreg;
                o_word_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_err      <= 1'b1;
              o_err_code <= ERR_LONG;
              r_state    <= stDiscard;
            end
          end
          stDiscard: begin
            if (w_dec.is_term) begin
              r_cnt   <= '0;
              r_state <= stCollect;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= stCollect;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed vector bench for uart_rx_decoder: each row is one cycle of inputs
// and the outputs expected in the following cycle.
module tb_uart_rx_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [15:0] o_word;
  logic        o_word_valid;
  logic        i_word_rdy;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_overrun;

  always #5 clk = ~clk;

  uart_rx_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_rdy   (i_word_rdy),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_overrun    (o_overrun)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [15:0] ew;
    logic        ee;
    logic [1:0]  ec;
    logic        eo;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic rdy,
                     input logic ev, input logic [15:0] ew, input logic ee,
                     input logic [1:0] ec, input logic eo);
    vec_t t;
    t.rst = r; t.vld = v; t.d = d; t.rdy = rdy;
    t.ev = ev; t.ew = ew; t.ee = ee; t.ec = ec; t.eo = eo;
    tv.push_back(t);
  endtask

  // Byte with no reset; expected outputs follow.
  task automatic b(input logic [7:0] d, input logic rdy, input logic ev, input logic [15:0] ew,
                   input logic ee, input logic [1:0] ec, input logic eo);
    add(1'b0, 1'b1, d, rdy, ev, ew, ee, ec, eo);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    rst = r; i_rx_valid = v; i_rx_data = d; i_word_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int errs;

    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_word_rdy = 1'b0;

    // reset state
    add(1'b1, 1'b0, 8'h00, 1'b0, 0, 16'h0000, 0, 2'd0, 0);
    add(1'b1, 1'b1, "A",   1'b0, 0, 16'h0000, 0, 2'd0, 0);
    // 1: "AZ" LF CR with ready high
    b("A",   1, 0, 16'h0000, 0, 0, 0);
    b("Z",   1, 0, 16'h0000, 0, 0, 0);
    b(8'h0A, 1, 1, 16'h0A23, 0, 0, 0);
    b(8'h0D, 1, 0, 16'h0A23, 0, 0, 0);
    // 2: "09" CR then "ab" LF, back to back
    b("0",   1, 0, 16'h0A23, 0, 0, 0);
    b("9",   1, 0, 16'h0A23, 0, 0, 0);
    b(8'h0D, 1, 1, 16'h0009, 0, 0, 0);
    b("a",   1, 0, 16'h0009, 0, 0, 0);
    b("b",   1, 0, 16'h0009, 0, 0, 0);
    b(8'h0A, 1, 1, 16'h0A0B, 0, 0, 0);
    // 3: short line, then recovery
    b("7",   1, 0, 16'h0A0B, 0, 0, 0);
    b(8'h0A, 1, 0, 16'h0A0B, 1, 2'd2, 0);
    b("1",   1, 0, 16'h0A0B, 0, 0, 0);
    b("2",   1, 0, 16'h0A0B, 0, 0, 0);
    b(8'h0A, 1, 1, 16'h0102, 0, 0, 0);
    // 4: bad char with silent discard, then long line
    b("B",   1, 0, 16'h0102, 0, 0, 0);
    b("#",   1, 0, 16'h0102, 1, 2'd1, 0);
    b("C",   1, 0, 16'h0102, 0, 0, 0);
    b(8'h0A, 1, 0, 16'h0102, 0, 0, 0);
    b("C",   1, 0, 16'h0102, 0, 0, 0);
    b("D",   1, 0, 16'h0102, 0, 0, 0);
    b("E",   1, 0, 16'h0102, 1, 2'd3, 0);
    b(8'h0A, 1, 0, 16'h0102, 0, 0, 0);
    // 5: holding register full -> overrun, idle cycles hold, ready drains
    b("1",   0, 0, 16'h0102, 0, 0, 0);
    b("1",   0, 0, 16'h0102, 0, 0, 0);
    b(8'h0A, 0, 1, 16'h0101, 0, 0, 0);
    b("2",   0, 1, 16'h0101, 0, 0, 0);
    b("2",   0, 1, 16'h0101, 0, 0, 0);
    b(8'h0A, 0, 1, 16'h0101, 0, 0, 1);
    add(1'b0, 1'b0, "5", 1'b0, 1, 16'h0101, 0, 2'd0, 0);
    add(1'b0, 1'b0, "5", 1'b1, 0, 16'h0101, 0, 2'd0, 0);
    //    commit with ready high replaces the held word
    b("1",   0, 0, 16'h0101, 0, 0, 0);
    b("1",   0, 0, 16'h0101, 0, 0, 0);
    b(8'h0A, 0, 1, 16'h0101, 0, 0, 0);
    b("2",   0, 1, 16'h0101, 0, 0, 0);
    b("2",   0, 1, 16'h0101, 0, 0, 0);
    b(8'h0A, 1, 1, 16'h0202, 0, 0, 0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 0, 16'h0202, 0, 2'd0, 0);
    // 6: reset mid-line with a held word
    b("3",   0, 0, 16'h0202, 0, 0, 0);
    b("3",   0, 0, 16'h0202, 0, 0, 0);
    b(8'h0A, 0, 1, 16'h0303, 0, 0, 0);
    b("Q",   0, 1, 16'h0303, 0, 0, 0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 0, 16'h0000, 0, 2'd0, 0);
    b("R",   0, 0, 16'h0000, 0, 0, 0);
    b(8'h0A, 0, 0, 16'h0000, 1, 2'd2, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].vld, tv[i].d, tv[i].rdy);
      n_vec++;
      if (o_word_valid !== tv[i].ev || o_word !== tv[i].ew || o_err !== tv[i].ee ||
          o_err_code !== tv[i].ec || o_overrun !== tv[i].eo) begin
        n_bad++;
        $display("FAIL vec%0d: got v=%b w=%h e=%b c=%0d o=%b, want v=%b w=%h e=%b c=%0d o=%b",
                 i, o_word_valid, o_word, o_err, o_err_code, o_overrun,
                 tv[i].ev, tv[i].ew, tv[i].ee, tv[i].ec, tv[i].eo);
      end
    end

    // Ready held high: "XY" LF CR LF gives one word pulse and no errors.
    pulses = 0; errs = 0;
    drive(0, 1, "X",   1); pulses += int'(o_word_valid); errs += int'(o_err);
    drive(0, 1, "Y",   1); pulses += int'(o_word_valid); errs += int'(o_err);
    drive(0, 1, 8'h0A, 1); pulses += int'(o_word_valid); errs += int'(o_err);
    n_vec++;
    if (o_word !== 16'h2122) begin
      n_bad++;
      $display("FAIL xy_word: got %h want 2122", o_word);
    end
    drive(0, 1, 8'h0D, 1); pulses += int'(o_word_valid); errs += int'(o_err);
    drive(0, 1, 8'h0A, 1); pulses += int'(o_word_valid); errs += int'(o_err);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1); pulses += int'(o_word_valid); errs += int'(o_err);
    end
    n_vec++;
    if (pulses != 1 || errs != 0) begin
      n_bad++;
      $display("FAIL xy_pulses: got valid=%0d err=%0d want valid=1 err=0", pulses, errs);
    end

    // Five-character line: exactly one long-line pulse, then resync.
    errs = 0;
    drive(0, 1, "1", 0); errs += int'(o_err);
    drive(0, 1, "2", 0); errs += int'(o_err);
    drive(0, 1, "3", 0); errs += int'(o_err);
    n_vec++;
    if (o_err !== 1'b1 || o_err_code !== 2'd3) begin
      n_bad++;
      $display("FAIL long_code: got e=%b c=%0d want e=1 c=3", o_err, o_err_code);
    end
    drive(0, 1, "4", 0); errs += int'(o_err);
    drive(0, 1, "5", 0); errs += int'(o_err);
    drive(0, 1, 8'h0A, 0); errs += int'(o_err);
    drive(0, 1, "6", 0); errs += int'(o_err);
    drive(0, 1, "7", 0); errs += int'(o_err);
    drive(0, 1, 8'h0A, 0); errs += int'(o_err);
    n_vec++;
    if (errs != 1 || o_word_valid !== 1'b1 || o_word !== 16'h0607) begin
      n_bad++;
      $display("FAIL long_resync: got errs=%0d v=%b w=%h want errs=1 v=1 w=0607",
               errs, o_word_valid, o_word);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
